alu_cmd_issuer: RTL and testbench
=================================

// Module: alu_cmd_issuer
// PURPOSE
// Initiator side of the ALU start/busy/valid handshake. Accepts tagged commands
// (op, A, B) on a valid/ready port and queues them in a FIFO. Issues them one at a
// time to the ALU, then returns {result, tag, status} on a valid/ready response port.
// Sits between the instruction front end and the ALU; the ALU is the only responder.
// PARAMETERS
// WIDTH      32    operand/result width
// TAGW       4     command tag width
// DEPTH      4     command FIFO entries, power of 2, >=2
// FIXED_LAT  3     cycles from alu_start pulse to result capture, fixed-latency ops
// TIMEOUT    1024  max cycles waiting for alu_valid before status=TIMEOUT
// PORTS
// clk        in   1         clock
// rst        in   1         reset
// cmd_valid  in   1         command offered
// cmd_ready  out  1         FIFO not full
// cmd_op     in   5         ALU opcode
// cmd_a      in   WIDTH     operand A
// cmd_b      in   WIDTH     operand B
// cmd_tag    in   TAGW      tag echoed on response
// alu_start  out  1         one-cycle issue pulse
// alu_op     out  5         opcode to ALU, held from issue to capture
// alu_a      out  WIDTH     operand A to ALU, held from issue to capture
// alu_b      out  WIDTH     operand B to ALU, held from issue to capture
// alu_busy   in   1         ALU multi-cycle unit busy
// alu_valid  in   1         ALU multi-cycle result valid
// alu_error  in   1         ALU error (divisor zero)
// alu_result in   WIDTH     ALU result
// rsp_valid  out  1         response available
// rsp_ready  in   1         consumer accepts response
// rsp_result out  WIDTH     captured result
// rsp_tag    out  TAGW      tag of completed command
// rsp_status out  2         00 OK, 01 ALU_ERR, 10 TIMEOUT
// cmd_level  out  clog2(DEPTH)+1   FIFO occupancy
// alu_hung   out  1         sticky; set on timeout, cleared only by rst
// BEHAVIOUR
// - Reset: rst is synchronous, active-high; clock is clk. On reset:
//   - FIFO is emptied; cmd_level=0; cmd_ready=1.
//   - alu_start=0; alu_op/alu_a/alu_b=0.
//   - rsp_valid=0; rsp_result=0; rsp_tag=0; rsp_status=0.
//   - alu_hung=0; FSM=IDLE.
//   - Reset mid-operation abandons the in-flight command; no response is produced.
// - FIFO push occurs on cmd_valid&cmd_ready. Pop occurs on the IDLE->ISSUE transition.
//   - A push and a pop in the same cycle leave the level unchanged.
//   - A push into a full FIFO is impossible because cmd_ready=0 when full.
// - Op classes:
//   - Fixed-latency: 0x00-0x07, 0x0C, 0x0D, 0x0F. Others, including undefined codes, complete at FIXED_LAT.
//   - Handshake: 0x08-0x0B, 0x0E. These complete on alu_valid.
// - FSM:
//   - IDLE: go to ISSUE when all hold: FIFO non-empty, rsp_valid=0, alu_busy=0, alu_hung=0.
//     On that edge, pop the FIFO and latch op/A/B/tag onto alu_*.
//   - ISSUE: alu_start=1 for exactly this cycle. Load the wait counter to 0.
//     Go to WAIT_FIX for fixed-latency ops, else WAIT_VAL.
//   - WAIT_FIX: count each cycle. When count==FIXED_LAT-1, capture alu_result with status 00, then go to RESP.
//   - WAIT_VAL: if alu_valid=1, capture alu_result; status=01 if alu_error else 00; go to RESP.
//     Else if count==TIMEOUT-1, set result=0, status=10, set alu_hung, go to RESP.
//     alu_valid on that same cycle wins over timeout.
//   - RESP: rsp_valid=1. On rsp_ready, clear rsp_valid and go to IDLE.
//     rsp_* stay stable while rsp_valid=1 and rsp_ready=0.
// - Issue timing:
//   - Earliest re-issue is the cycle after the response handshake, so at least 1 idle cycle separates alu_start pulses.
//   - alu_valid/alu_error seen outside WAIT_VAL are ignored.
// - Ordering: responses come back in command order, one command in flight.
// - Latency: an empty-FIFO command seen at cycle t gives earliest rsp_valid at cycle t+3+FIXED_LAT (fixed-latency op).
// TESTING
// - Op 0x06, A=5, B=7, tag=3 -> one alu_start pulse; rsp_result=12, rsp_tag=3, status=00, FIXED_LAT cycles after start.
// - Op 0x0A, B=0; ALU returns valid with error=1 -> status=01 and the next queued command still issues.
// - Push DEPTH+1 commands with rsp_ready=0 -> cmd_ready drops at full; responses come out in order once ready rises.
// - Op 0x09 and alu_valid never arrives -> after TIMEOUT cycles status=10, result=0, alu_hung=1, no further alu_start.
// - Assert rst during WAIT_VAL -> next cycle all outputs at reset values; a fresh command completes normally.
// - Hold rsp_ready=0 for 5 cycles -> rsp_* stable; no new alu_start until the handshake completes.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer
//
// Initiator side of the ALU start/busy/valid handshake. Tagged commands
// (op, A, B, tag) are accepted on a valid/ready port and queued in a small
// FIFO. One command at a time is issued to the ALU. The result is then
// returned as {result, tag, status} on a valid/ready response port, in
// command order.
//
// Handshake rule used on both the command and the response port: a transfer
// happens on a rising clk edge where valid and ready are both high. The
// sender holds its payload stable while valid is high and ready is low.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   cmd_valid/ready   command port; cmd_ready is high while the FIFO is not full
//   cmd_op/a/b/tag    command payload
//   alu_start         one-cycle issue pulse
//   alu_op/a/b        operands to the ALU, held from issue to capture
//   alu_busy          ALU multi-cycle unit busy; blocks issue
//   alu_valid/error   handshake-op completion and error (divide by zero)
//   alu_result        ALU result
//   rsp_valid/ready   response port
//   rsp_result/tag    captured result and the tag of the completed command
//   rsp_status        00 OK, 01 ALU_ERR, 10 TIMEOUT
//   cmd_level         FIFO occupancy
//   alu_hung          sticky; set on a timeout, cleared only by rst
//   fsm_state         current FSM state, for observation
// ---------------------------------------------------------------------------
module alu_cmd_issuer #(
    parameter int WIDTH     = 32,
    parameter int TAGW      = 4,
    parameter int DEPTH     = 4,
    parameter int FIXED_LAT = 3,
    parameter int TIMEOUT   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [4:0]             cmd_op,
    input  logic [WIDTH-1:0]       cmd_a,
    input  logic [WIDTH-1:0]       cmd_b,
    input  logic [TAGW-1:0]        cmd_tag,
    output logic                   alu_start,
    output logic [4:0]             alu_op,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    input  logic                   alu_busy,
    input  logic                   alu_valid,
    input  logic                   alu_error,
    input  logic [WIDTH-1:0]       alu_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_result,
    output logic [TAGW-1:0]        rsp_tag,
    output logic [1:0]             rsp_status,
    output logic [$clog2(DEPTH):0] cmd_level,
    output logic                   alu_hung,
    output logic [2:0]             fsm_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    // FIFO entry layout: {op, a, b, tag}
    localparam int EW = 5 + 2 * WIDTH + TAGW;

    // The wait counter must reach both TIMEOUT-1 and FIXED_LAT-1.
    localparam int CNT_TOP = (TIMEOUT > FIXED_LAT) ? TIMEOUT : FIXED_LAT;
    localparam int CW      = $clog2(CNT_TOP) + 1;
    localparam logic [CW-1:0] FIX_LAST = CW'(FIXED_LAT - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ALU_ERR = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT_FIX = 3'd2,
        S_WAIT_VAL = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // Ops that finish on alu_valid; everything else, including undefined
    // codes, is treated as fixed latency.
    function automatic logic is_handshake(input logic [4:0] op);
        logic hs;
        hs = 1'b0;
        case (op)
            5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0E: hs = 1'b1;
            default:                           hs = 1'b0;
        endcase
        return hs;
    endfunction

    // -----------------------------------------------------------------------
    // Command FIFO
    // -----------------------------------------------------------------------
    logic [EW-1:0] fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [EW-1:0] fifo_head;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          issue_go;

    assign fifo_empty = (cmd_level == '0);
    assign cmd_ready  = (cmd_level != LW'(DEPTH));
    assign push       = cmd_valid & cmd_ready;
    assign fifo_head  = fifo_mem[rd_ptr];

    // Issue needs a queued command, a free response slot, an idle ALU and
    // a healthy ALU. The pop happens on the same edge as IDLE->ISSUE.
    assign issue_go = (state == S_IDLE) && !fifo_empty && !rsp_valid &&
                      !alu_busy && !alu_hung;
    assign pop      = issue_go;

    // Storage has no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b, cmd_tag};
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    logic [CW-1:0] wait_cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (issue_go) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                // alu_op was latched on entry to ISSUE, so it classifies
                // the command being issued.
                state_nxt = is_handshake(alu_op) ? S_WAIT_VAL : S_WAIT_FIX;
            end
            S_WAIT_FIX: begin
                if (wait_cnt == FIX_LAST) state_nxt = S_RESP;
            end
            S_WAIT_VAL: begin
                if (alu_valid || (wait_cnt == TO_LAST)) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        alu_start = (state == S_ISSUE);
        rsp_valid = (state == S_RESP);
        fsm_state = state;
    end

    // -----------------------------------------------------------------------
    // Datapath: FIFO pointers, issue registers, wait counter, capture
    // -----------------------------------------------------------------------
    logic [TAGW-1:0] cur_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cmd_level  <= '0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            cur_tag    <= '0;
            wait_cnt   <= '0;
            rsp_result <= '0;
            rsp_tag    <= '0;
            rsp_status <= ST_OK;
            alu_hung   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);

            case ({push, pop})
                2'b10:   cmd_level <= cmd_level + LW'(1);
                2'b01:   cmd_level <= cmd_level - LW'(1);
                default: cmd_level <= cmd_level;
            endcase

            // Operands stay on alu_* from issue until the next issue,
            // which covers the required issue-to-capture window.
            if (issue_go) begin
                alu_op  <= fifo_head[EW-1 -: 5];
                alu_a   <= fifo_head[EW-6 -: WIDTH];
                alu_b   <= fifo_head[TAGW+WIDTH-1 -: WIDTH];
                cur_tag <= fifo_head[TAGW-1:0];
            end

            case (state)
                S_ISSUE: begin
                    wait_cnt <= '0;
                end
                S_WAIT_FIX: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (wait_cnt == FIX_LAST) begin
                        rsp_result <= alu_result;
                        rsp_tag    <= cur_tag;
                        rsp_status <= ST_OK;
                    end
                end
                S_WAIT_VAL: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    // A result arriving on the last counted cycle still
                    // counts as a normal completion.
                    if (alu_valid) begin
                        rsp_result <= alu_result;
                        rsp_tag    <= cur_tag;
                        rsp_status <= alu_error ? ST_ALU_ERR : ST_OK;
                    end else if (wait_cnt == TO_LAST) begin
                        rsp_result <= '0;
                        rsp_tag    <= cur_tag;
                        rsp_status <= ST_TIMEOUT;
                        alu_hung   <= 1'b1;
                    end
                end
                default: begin
                    wait_cnt <= wait_cnt;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Protocol properties
    // -----------------------------------------------------------------------
    a_start_pulse: assert property (@(posedge clk) disable iff (rst)
        alu_start |=> !alu_start);

    a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
        (rsp_valid && !rsp_ready) |=>
            (rsp_valid && $stable(rsp_result) && $stable(rsp_tag) &&
             $stable(rsp_status)));

    a_level_bound: assert property (@(posedge clk) disable iff (rst)
        cmd_level <= LW'(DEPTH));

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_issuer
//
// Directed bench for alu_cmd_issuer. A small ALU responder answers issued
// commands: fixed-latency results are combinational from alu_op/a/b, and
// handshake ops get alu_valid after a programmable delay. Inputs change and
// outputs are sampled on the falling edge of clk.
// ---------------------------------------------------------------------------
module tb_alu_cmd_issuer;

    localparam int WIDTH     = 32;
    localparam int TAGW      = 4;
    localparam int DEPTH     = 4;
    localparam int FIXED_LAT = 3;
    localparam int TIMEOUT   = 1024;
    localparam int LW        = $clog2(DEPTH) + 1;
    localparam int QW        = TAGW + 2 + WIDTH;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [4:0]        cmd_op;
    logic [WIDTH-1:0]  cmd_a;
    logic [WIDTH-1:0]  cmd_b;
    logic [TAGW-1:0]   cmd_tag;
    logic              alu_start;
    logic [4:0]        alu_op;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic              alu_busy;
    logic              alu_valid = 1'b0;
    logic              alu_error = 1'b0;
    logic [WIDTH-1:0]  alu_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_result;
    logic [TAGW-1:0]   rsp_tag;
    logic [1:0]        rsp_status;
    logic [LW-1:0]     cmd_level;
    logic              alu_hung;
    logic [2:0]        fsm_state;

    logic              hs_respond;
    int                hs_delay;
    int                hs_cnt = -1;

    logic [QW-1:0]     exp_q[$];
    int                pass_cnt  = 0;
    int                total_cnt = 0;

    alu_cmd_issuer #(
        .WIDTH(WIDTH), .TAGW(TAGW), .DEPTH(DEPTH),
        .FIXED_LAT(FIXED_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_busy(alu_busy), .alu_valid(alu_valid), .alu_error(alu_error),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_status(rsp_status),
        .cmd_level(cmd_level), .alu_hung(alu_hung), .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    // ---------------- ALU responder ----------------
    function automatic logic tb_is_hs(input logic [4:0] op);
        return op inside {5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0E};
    endfunction

    // 0x06 adds, 0x0A divides (all-ones on divide by zero), others XOR.
    always_comb begin
        if (alu_op == 5'h06)      alu_result = alu_a + alu_b;
        else if (alu_op == 5'h0A) alu_result = (alu_b == '0) ? '1 : alu_a / alu_b;
        else                      alu_result = alu_a ^ alu_b;
    end

    always @(posedge clk) begin
        if (rst) begin
            alu_valid <= 1'b0;
            alu_error <= 1'b0;
            hs_cnt    <= -1;
        end else begin
            alu_valid <= 1'b0;
            alu_error <= 1'b0;
            if (alu_start && tb_is_hs(alu_op) && hs_respond) begin
                hs_cnt <= hs_delay;
            end else if (hs_cnt == 0) begin
                alu_valid <= 1'b1;
                alu_error <= (alu_b == '0);
                hs_cnt    <= -1;
            end else if (hs_cnt > 0) begin
                hs_cnt <= hs_cnt - 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_cmd(input logic [4:0] op, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic [TAGW-1:0] tag);
        int guard;
        guard = 0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            total_cnt++;
            $display("FAIL push_wait: cmd_ready=%b after %0d cycles, required 1", cmd_ready, guard);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic collect_rsp(input int budget, output logic [WIDTH-1:0] res,
                               output logic [TAGW-1:0] tag, output logic [1:0] st);
        int waited;
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        total_cnt++;
        if (rsp_valid !== 1'b1)
            $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, waited);
        else
            pass_cnt++;
        res = rsp_result; tag = rsp_tag; st = rsp_status;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (cmd_level !== '0 || cmd_ready !== 1'b1)
            $display("FAIL reset_fifo: level=%0d ready=%b, required 0/1", cmd_level, cmd_ready);
        else pass_cnt++;
        total_cnt++;
        if (alu_start !== 1'b0 || alu_op !== 5'd0 || alu_a !== '0 || alu_b !== '0)
            $display("FAIL reset_alu: start=%b op=%0h a=%0h b=%0h, required all 0",
                     alu_start, alu_op, alu_a, alu_b);
        else pass_cnt++;
        total_cnt++;
        if (rsp_valid !== 1'b0 || rsp_result !== '0 || rsp_tag !== '0 || rsp_status !== 2'b00)
            $display("FAIL reset_rsp: valid=%b result=%0h tag=%0h status=%b, required all 0",
                     rsp_valid, rsp_result, rsp_tag, rsp_status);
        else pass_cnt++;
        total_cnt++;
        if (alu_hung !== 1'b0 || fsm_state !== 3'd0)
            $display("FAIL reset_state: hung=%b state=%0d, required 0/0", alu_hung, fsm_state);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fixed_op();
        int starts;
        int early;
        starts = 0;
        early  = 0;
        cmd_op = 5'h06; cmd_a = 32'd5; cmd_b = 32'd7; cmd_tag = 4'd3; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        total_cnt++;
        if (cmd_level !== LW'(1) || alu_start !== 1'b0)
            $display("FAIL fix_queued: level=%0d start=%b, required 1/0", cmd_level, alu_start);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (alu_start !== 1'b1 || alu_op !== 5'h06 || alu_a !== 32'd5 || alu_b !== 32'd7 || cmd_level !== '0)
            $display("FAIL fix_issue: start=%b op=%0h a=%0d b=%0d level=%0d, required 1/6/5/7/0",
                     alu_start, alu_op, alu_a, alu_b, cmd_level);
        else pass_cnt++;
        for (int i = 3; i <= 5; i++) begin
            @(negedge clk);
            if (alu_start === 1'b1) starts++;
            if (rsp_valid === 1'b1) early++;
        end
        @(negedge clk);
        total_cnt++;
        if (rsp_valid !== 1'b1 || starts != 0 || early != 0)
            $display("FAIL fix_latency: rsp_valid=%b extra_starts=%0d early_valid=%0d, required 1/0/0",
                     rsp_valid, starts, early);
        else pass_cnt++;
        total_cnt++;
        if (rsp_result !== 32'd12 || rsp_tag !== 4'd3 || rsp_status !== 2'b00)
            $display("FAIL fix_rsp: result=%0d tag=%0d status=%b, required 12/3/00",
                     rsp_result, rsp_tag, rsp_status);
        else pass_cnt++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total_cnt++;
        if (rsp_valid !== 1'b0)
            $display("FAIL fix_release: rsp_valid=%b, required 0", rsp_valid);
        else pass_cnt++;
    endtask

    task automatic test_error_next();
        logic [WIDTH-1:0] r;
        logic [TAGW-1:0]  t;
        logic [1:0]       s;
        hs_respond = 1'b1;
        hs_delay   = 2;
        push_cmd(5'h0A, 32'd100, 32'd0, 4'd5);
        push_cmd(5'h06, 32'd1, 32'd2, 4'd6);
        collect_rsp(50, r, t, s);
        total_cnt++;
        if (r !== 32'hFFFF_FFFF || t !== 4'd5 || s !== 2'b01)
            $display("FAIL err_rsp: result=%0h tag=%0d status=%b, required ffffffff/5/01", r, t, s);
        else pass_cnt++;
        collect_rsp(50, r, t, s);
        total_cnt++;
        if (r !== 32'd3 || t !== 4'd6 || s !== 2'b00)
            $display("FAIL err_next: result=%0h tag=%0d status=%b, required 3/6/00", r, t, s);
        else pass_cnt++;
    endtask

    task automatic test_fill_order();
        logic [4:0]       ops[5] = '{5'h06, 5'h0C, 5'h0B, 5'h0F, 5'h0D};
        logic [WIDTH-1:0] as[5]  = '{32'd10, 32'h14, 32'h30, 32'h44, 32'h50};
        logic [WIDTH-1:0] bs[5]  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        logic [WIDTH-1:0] r;
        logic [TAGW-1:0]  t;
        logic [1:0]       s;
        logic [QW-1:0]    exp;
        int               bad;
        hs_respond = 1'b1;
        hs_delay   = 2;
        exp_q.push_back({4'd1, 2'b00, 32'h0000_000B});
        exp_q.push_back({4'd2, 2'b00, 32'h0000_0016});
        exp_q.push_back({4'd3, 2'b00, 32'h0000_0033});
        exp_q.push_back({4'd4, 2'b00, 32'h0000_0040});
        exp_q.push_back({4'd5, 2'b00, 32'h0000_0055});
        for (int i = 0; i < 5; i++) push_cmd(ops[i], as[i], bs[i], TAGW'(i + 1));
        total_cnt++;
        if (cmd_ready !== 1'b0 || cmd_level !== LW'(DEPTH))
            $display("FAIL fill_full: ready=%b level=%0d, required 0/%0d", cmd_ready, cmd_level, DEPTH);
        else pass_cnt++;
        // A sixth command offered while full must not enter.
        bad = 0;
        cmd_op = 5'h06; cmd_a = 32'd99; cmd_b = 32'd99; cmd_tag = 4'd15; cmd_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0 || cmd_level !== LW'(DEPTH)) bad++;
        end
        cmd_valid = 1'b0;
        total_cnt++;
        if (bad != 0)
            $display("FAIL fill_blocked: %0d cycles with ready=%b level=%0d, required 0 cycles",
                     bad, cmd_ready, cmd_level);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            collect_rsp(50, r, t, s);
            exp = exp_q.pop_front();
            total_cnt++;
            if ({t, s, r} !== exp)
                $display("FAIL fill_order_%0d: tag=%0d status=%b result=%0h, required tag=%0d status=%b result=%0h",
                         i, t, s, r, exp[QW-1 -: TAGW], exp[WIDTH+1 -: 2], exp[WIDTH-1:0]);
            else pass_cnt++;
        end
        total_cnt++;
        if (cmd_level !== '0)
            $display("FAIL fill_drained: level=%0d, required 0", cmd_level);
        else pass_cnt++;
    endtask

    task automatic test_rsp_hold();
        logic [WIDTH-1:0] r;
        logic [TAGW-1:0]  t;
        logic [1:0]       s;
        int               n;
        int               bad;
        push_cmd(5'h06, 32'd20, 32'd22, 4'd7);
        push_cmd(5'h06, 32'd1, 32'd1, 4'd8);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (rsp_valid !== 1'b1)
            $display("FAIL hold_arrive: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
        else pass_cnt++;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_result !== 32'd42 || rsp_tag !== 4'd7 ||
                rsp_status !== 2'b00 || alu_start !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad != 0)
            $display("FAIL hold_stable: %0d bad cycles (valid=%b result=%0d tag=%0d start=%b), required 0",
                     bad, rsp_valid, rsp_result, rsp_tag, alu_start);
        else pass_cnt++;
        total_cnt++;
        if (cmd_level !== LW'(1))
            $display("FAIL hold_queued: level=%0d, required 1", cmd_level);
        else pass_cnt++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total_cnt++;
        if (rsp_valid !== 1'b0 || alu_start !== 1'b0)
            $display("FAIL hold_gap: rsp_valid=%b start=%b, required 0/0", rsp_valid, alu_start);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (alu_start !== 1'b1 || alu_a !== 32'd1)
            $display("FAIL hold_reissue: start=%b a=%0d, required 1/1", alu_start, alu_a);
        else pass_cnt++;
        collect_rsp(50, r, t, s);
        total_cnt++;
        if (r !== 32'd2 || t !== 4'd8 || s !== 2'b00)
            $display("FAIL hold_second: result=%0d tag=%0d status=%b, required 2/8/00", r, t, s);
        else pass_cnt++;
    endtask

    task automatic test_busy_block();
        logic [WIDTH-1:0] r;
        logic [TAGW-1:0]  t;
        logic [1:0]       s;
        int               starts;
        starts   = 0;
        alu_busy = 1'b1;
        push_cmd(5'h06, 32'd2, 32'd3, 4'd12);
        repeat (4) begin
            @(negedge clk);
            if (alu_start === 1'b1) starts++;
        end
        total_cnt++;
        if (starts != 0 || cmd_level !== LW'(1))
            $display("FAIL busy_block: starts=%0d level=%0d, required 0/1", starts, cmd_level);
        else pass_cnt++;
        alu_busy = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (alu_start !== 1'b1)
            $display("FAIL busy_release: start=%b, required 1", alu_start);
        else pass_cnt++;
        collect_rsp(50, r, t, s);
        total_cnt++;
        if (r !== 32'd5 || t !== 4'd12 || s !== 2'b00)
            $display("FAIL busy_rsp: result=%0d tag=%0d status=%b, required 5/12/00", r, t, s);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] r;
        logic [TAGW-1:0]  t;
        logic [1:0]       s;
        int               bad;
        hs_respond = 1'b0;
        push_cmd(5'h08, 32'd7, 32'd7, 4'd4);
        push_cmd(5'h06, 32'd1, 32'd1, 4'd5);
        repeat (3) @(negedge clk);
        total_cnt++;
        if (alu_op !== 5'h08 || cmd_level !== LW'(1) || rsp_valid !== 1'b0)
            $display("FAIL mid_waiting: op=%0h level=%0d rsp_valid=%b, required 8/1/0",
                     alu_op, cmd_level, rsp_valid);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (cmd_level !== '0 || cmd_ready !== 1'b1 || alu_start !== 1'b0 || alu_op !== 5'd0 ||
            alu_a !== '0 || alu_b !== '0 || rsp_valid !== 1'b0 || rsp_result !== '0 ||
            rsp_tag !== '0 || rsp_status !== 2'b00 || alu_hung !== 1'b0)
            $display("FAIL mid_reset: level=%0d ready=%b start=%b op=%0h a=%0h rsp_valid=%b tag=%0d hung=%b, required reset values",
                     cmd_level, cmd_ready, alu_start, alu_op, alu_a, rsp_valid, rsp_tag, alu_hung);
        else pass_cnt++;
        rst        = 1'b0;
        hs_respond = 1'b1;
        hs_delay   = 2;
        bad        = 0;
        repeat (5) begin
            @(negedge clk);
            if (alu_start === 1'b1 || rsp_valid === 1'b1) bad++;
        end
        total_cnt++;
        if (bad != 0)
            $display("FAIL mid_abandon: %0d cycles with start or rsp_valid, required 0", bad);
        else pass_cnt++;
        push_cmd(5'h06, 32'd3, 32'd4, 4'd9);
        collect_rsp(50, r, t, s);
        total_cnt++;
        if (r !== 32'd7 || t !== 4'd9 || s !== 2'b00)
            $display("FAIL mid_fresh: result=%0d tag=%0d status=%b, required 7/9/00", r, t, s);
        else pass_cnt++;
    endtask

    task automatic test_valid_wins();
        logic [WIDTH-1:0] r;
        logic [TAGW-1:0]  t;
        logic [1:0]       s;
        hs_respond = 1'b1;
        hs_delay   = TIMEOUT - 2;   // alu_valid lands on the last counted cycle
        push_cmd(5'h09, 32'h55, 32'h0F, 4'd2);
        collect_rsp(TIMEOUT + 50, r, t, s);
        total_cnt++;
        if (r !== 32'h5A || t !== 4'd2 || s !== 2'b00)
            $display("FAIL edge_valid: result=%0h tag=%0d status=%b, required 5a/2/00", r, t, s);
        else pass_cnt++;
        total_cnt++;
        if (alu_hung !== 1'b0)
            $display("FAIL edge_hung: alu_hung=%b, required 0", alu_hung);
        else pass_cnt++;
        hs_delay = 2;
    endtask

    task automatic test_timeout();
        int n;
        int starts;
        hs_respond = 1'b0;
        alu_busy   = 1'b1;
        push_cmd(5'h09, 32'd1, 32'd2, 4'd10);
        push_cmd(5'h06, 32'd1, 32'd1, 4'd11);
        alu_busy = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (alu_start !== 1'b1 || alu_op !== 5'h09)
            $display("FAIL to_issue: start=%b op=%0h, required 1/9", alu_start, alu_op);
        else pass_cnt++;
        n = 0;
        while (rsp_valid !== 1'b1 && n < TIMEOUT + 20) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (n != TIMEOUT + 1)
            $display("FAIL to_cycles: rsp_valid after %0d cycles, required %0d", n, TIMEOUT + 1);
        else pass_cnt++;
        total_cnt++;
        if (rsp_result !== '0 || rsp_tag !== 4'd10 || rsp_status !== 2'b10 || alu_hung !== 1'b1)
            $display("FAIL to_rsp: result=%0h tag=%0d status=%b hung=%b, required 0/10/10/1",
                     rsp_result, rsp_tag, rsp_status, alu_hung);
        else pass_cnt++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        starts = 0;
        repeat (20) begin
            @(negedge clk);
            if (alu_start === 1'b1) starts++;
        end
        total_cnt++;
        if (starts != 0 || cmd_level !== LW'(1) || alu_hung !== 1'b1)
            $display("FAIL to_stalled: starts=%0d level=%0d hung=%b, required 0/1/1",
                     starts, cmd_level, alu_hung);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (alu_hung !== 1'b0 || cmd_level !== '0)
            $display("FAIL to_cleared: hung=%b level=%0d, required 0/0", alu_hung, cmd_level);
        else pass_cnt++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = '0;
        cmd_a      = '0;
        cmd_b      = '0;
        cmd_tag    = '0;
        alu_busy   = 1'b0;
        rsp_ready  = 1'b0;
        hs_respond = 1'b1;
        hs_delay   = 2;

        test_reset();
        test_fixed_op();
        test_error_next();
        test_fill_order();
        test_rsp_hold();
        test_busy_block();
        test_reset_mid();
        test_valid_wins();
        test_timeout();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
